// File: rtl/rom_loader.sv
// rom_loader: assembles a little-endian byte stream into 32-bit ROM words and holds the core in reset until loaded.
// Optional trailing checksum byte is built in when LOADER_CHECKSUM_EN is defined.
module rom_loader #(
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
   parameter int unsigned DEPTH_WORDS = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  byte_i,
   input  logic        byte_valid_i,
   output logic        byte_ready_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   output logic        cpu_rst_n_o,
   output logic        done_o,
   output logic        err_o
);
   typedef enum logic [2:0] {
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
`ifdef LOADER_CHECKSUM_EN
      S_CHK,
`endif
      S_DONE,
      S_ERR
   } state_t;
   state_t      r_state;
   logic        r_ready;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_data;
   logic        r_cpu_rst_n;
   logic        r_done;
   logic        r_err;
   logic [15:0] r_len;
   logic [15:0] r_idx;
   logic [1:0]  r_cnt;
   logic [23:0] r_word;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  r_sum;
`endif
   logic        w_take;
   logic [15:0] w_len;
   logic [31:0] w_word;
   logic        w_last;
   assign w_take = byte_valid_i & r_ready;
   assign w_len  = {byte_i, r_len[7:0]};
   assign w_word = {byte_i, r_word};
   assign w_last = (r_idx + 16'd1) == r_len;
   assign byte_ready_o = r_ready;
   assign mem_we_o     = r_we;
   assign mem_addr_o   = r_addr;
   assign mem_data_o   = r_data;
   assign cpu_rst_n_o  = r_cpu_rst_n;
   assign done_o       = r_done;
   assign err_o        = r_err;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_LEN_LO;
         r_ready     <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= ADDR_BASE;
         r_data      <= 32'd0;
         r_cpu_rst_n <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_len       <= 16'd0;
         r_idx       <= 16'd0;
         r_cnt       <= 2'd0;
         r_word      <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
         r_sum       <= 8'd0;
`endif
      end else begin
         r_we        <= 1'b0;
         // core leaves reset one edge after done, so the last ROM write has landed
         r_cpu_rst_n <= r_done;
         case (r_state)
            S_LEN_LO: begin
               r_ready <= 1'b1;
               if (w_take) begin
                  r_len[7:0] <= byte_i;
                  r_state    <= S_LEN_HI;
               end
            end
            S_LEN_HI: if (w_take) begin
               r_len <= w_len;
               if ({16'd0, w_len} > DEPTH_WORDS) begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
                  r_ready <= 1'b0;
               end else if (w_len == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                  r_state <= S_CHK;
`else
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_ready <= 1'b0;
`endif
               end else begin
                  r_state <= S_DATA;
               end
            end
            S_DATA: if (w_take) begin
               r_cnt  <= r_cnt + 2'd1;
               r_word <= w_word[31:8];
`ifdef LOADER_CHECKSUM_EN
               r_sum  <= r_sum + byte_i;
`endif
               if (r_cnt == 2'd3) begin
                  r_we   <= 1'b1;
                  r_addr <= ADDR_BASE + {14'd0, r_idx, 2'b00};
                  r_data <= w_word;
                  r_idx  <= r_idx + 16'd1;
                  if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
                     r_state <= S_CHK;
`else
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_ready <= 1'b0;
`endif
                  end
               end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: if (w_take) begin
               r_ready <= 1'b0;
               if (r_sum + byte_i == 8'd0) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
               end
            end
`endif
            default: r_ready <= 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: scoreboard bench for rom_loader; expected ROM writes are queued as bytes are sent.
module tb_rom_loader;
   localparam logic [31:0] BASE = 32'h0000_0000;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  byte_i = 8'd0;
   logic        byte_valid_i = 1'b0;
   logic        byte_ready_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic        cpu_rst_n_o;
   logic        done_o;
   logic        err_o;
   int          checks = 0;
   int          failures = 0;
   int          writes = 0;
   logic [63:0] exp_q[$];
   logic [63:0] mon_e;
   logic [31:0] img[$];

   always #5 clk = ~clk;

   rom_loader #(.ADDR_BASE(BASE), .DEPTH_WORDS(4096)) dut (
      .clk(clk), .rst_n(rst_n), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
      .byte_ready_o(byte_ready_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .cpu_rst_n_o(cpu_rst_n_o), .done_o(done_o), .err_o(err_o)
   );

   always @(negedge clk) begin
      if (rst_n && mem_we_o) begin
         writes++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL write_unexpected got addr=%h data=%h, none expected", mem_addr_o, mem_data_o);
         end else begin
            mon_e = exp_q.pop_front();
            if ({mem_addr_o, mem_data_o} !== mon_e) begin
               failures++;
               $display("FAIL write got addr=%h data=%h expected addr=%h data=%h",
                        mem_addr_o, mem_data_o, mon_e[63:32], mon_e[31:0]);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      byte_i = b;
      byte_valid_i = 1'b1;
      while (!byte_ready_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready_o) begin
         checks++;
         failures++;
         $display("FAIL ready_timeout byte=%h ready=%b expected 1", b, byte_ready_o);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      byte_valid_i = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic send_image(input bit gap, input string tag);
      logic [7:0] sum;
      logic [7:0] b[$];
      logic       we_exp;
      int         n;
      sum = 8'd0;
      b = {};
      n = img.size();
      b.push_back(8'(n));
      b.push_back(8'(n >> 8));
      foreach (img[i]) begin
         exp_q.push_back({BASE + 32'(4 * i), img[i]});
         for (int k = 0; k < 4; k++) begin
            b.push_back(img[i][8*k +: 8]);
            sum += img[i][8*k +: 8];
         end
      end
`ifdef LOADER_CHECKSUM_EN
      b.push_back(8'd0 - sum);
      we_exp = 1'b0;
`else
      we_exp = (n > 0);
`endif
      foreach (b[i]) begin
         if (gap && i > 0) begin
            byte_valid_i = 1'b0;
            @(posedge clk);
            #1;
         end
         send_byte(b[i]);
      end
      byte_valid_i = 1'b0;
      checks++;
      if ({done_o, err_o, cpu_rst_n_o, byte_ready_o} !== 4'b1000) begin
         failures++;
         $display("FAIL %s_final_edge got done,err,cpu_rst_n,ready=%b expected 1000", tag,
                  {done_o, err_o, cpu_rst_n_o, byte_ready_o});
      end
      checks++;
      if (mem_we_o !== we_exp) begin
         failures++;
         $display("FAIL %s_last_we got %b expected %b", tag, mem_we_o, we_exp);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({cpu_rst_n_o, mem_we_o, done_o} !== 3'b101) begin
         failures++;
         $display("FAIL %s_release got cpu_rst_n,we,done=%b expected 101", tag, {cpu_rst_n_o, mem_we_o, done_o});
      end
      checks++;
      if (exp_q.size() !== 0) begin
         failures++;
         $display("FAIL %s_pending got %0d writes outstanding expected 0", tag, exp_q.size());
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({byte_ready_o, mem_we_o, cpu_rst_n_o, done_o, err_o} !== 5'b0 ||
          mem_addr_o !== BASE || mem_data_o !== 32'd0) begin
         failures++;
         $display("FAIL reset_values got ready,we,cpu,done,err=%b addr=%h data=%h expected 00000 %h 0",
                  {byte_ready_o, mem_we_o, cpu_rst_n_o, done_o, err_o}, mem_addr_o, mem_data_o, BASE);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (byte_ready_o !== 1'b0) begin
         failures++;
         $display("FAIL ready_before_edge got %b expected 0", byte_ready_o);
      end
      @(posedge clk);
      #1;
      checks++;
      if (byte_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_edge got %b expected 1", byte_ready_o);
      end
   endtask

   task automatic test_back_to_back();
      img = {32'h0000_0013, 32'h0010_0093};
      send_image(1'b0, "b2b");
   endtask

   task automatic test_gapped();
      do_reset();
      img = {32'h0000_0013, 32'h0010_0093};
      send_image(1'b1, "gapped");
   endtask

   task automatic test_empty();
      int w0;
      do_reset();
      w0 = writes;
      img = {};
      send_image(1'b0, "empty");
      checks++;
      if (writes !== w0) begin
         failures++;
         $display("FAIL empty_writes got %0d expected 0", writes - w0);
      end
   endtask

   task automatic test_overlength();
      int w0;
      do_reset();
      w0 = writes;
      send_byte(8'h01);
      send_byte(8'h10);
      byte_valid_i = 1'b0;
      checks++;
      if ({err_o, done_o, byte_ready_o, cpu_rst_n_o} !== 4'b1000) begin
         failures++;
         $display("FAIL overlength_err got err,done,ready,cpu=%b expected 1000", {err_o, done_o, byte_ready_o, cpu_rst_n_o});
      end
      byte_i = 8'h55;
      byte_valid_i = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      byte_valid_i = 1'b0;
      checks++;
      if (writes !== w0 || {err_o, cpu_rst_n_o, byte_ready_o} !== 3'b100) begin
         failures++;
         $display("FAIL overlength_hold got writes=%0d err,cpu,ready=%b expected 0 100",
                  writes - w0, {err_o, cpu_rst_n_o, byte_ready_o});
      end
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_checksum();
      logic [7:0] bytes[$];
      do_reset();
      img = {32'hDDCC_BBAA};
      send_image(1'b0, "chk_good");
      do_reset();
      exp_q.push_back({BASE, 32'hDDCC_BBAA});
      bytes = {8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h13};
      foreach (bytes[i]) send_byte(bytes[i]);
      byte_valid_i = 1'b0;
      checks++;
      if ({err_o, done_o, cpu_rst_n_o, byte_ready_o} !== 4'b1000) begin
         failures++;
         $display("FAIL chk_bad got err,done,cpu,ready=%b expected 1000", {err_o, done_o, cpu_rst_n_o, byte_ready_o});
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (cpu_rst_n_o !== 1'b0 || exp_q.size() !== 0) begin
         failures++;
         $display("FAIL chk_bad_hold got cpu_rst_n=%b pending=%0d expected 0 0", cpu_rst_n_o, exp_q.size());
      end
   endtask
`endif

   task automatic test_mid_reset();
      logic [7:0] bytes[$];
      do_reset();
      exp_q.push_back({BASE, 32'h0000_0013});
      bytes = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
      foreach (bytes[i]) send_byte(bytes[i]);
      byte_valid_i = 1'b0;
      rst_n = 1'b0;
      #2;
      checks++;
      if ({byte_ready_o, mem_we_o, cpu_rst_n_o, done_o, err_o} !== 5'b0 ||
          mem_addr_o !== BASE || mem_data_o !== 32'd0) begin
         failures++;
         $display("FAIL midreset_values got ready,we,cpu,done,err=%b addr=%h data=%h expected 00000 %h 0",
                  {byte_ready_o, mem_we_o, cpu_rst_n_o, done_o, err_o}, mem_addr_o, mem_data_o, BASE);
      end
      checks++;
      if (exp_q.size() !== 0) begin
         failures++;
         $display("FAIL midreset_first_word got %0d pending expected 0", exp_q.size());
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      img = {32'h0000_0013, 32'h0010_0093};
      send_image(1'b0, "replay");
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_gapped();
      test_empty();
      test_overlength();
`ifdef LOADER_CHECKSUM_EN
      test_checksum();
`endif
      test_mid_reset();
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
